// File: rtl/farm_car_detector.sv
// Farm-road vehicle detector: synchronises and debounces the loop sensor, counts waiting
// cars and holds the car request C until the traffic light controller grants farm green.
module farm_car_detector #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned MAX_WAIT   = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             loop_raw,
    input  logic             FG,
    input  logic             FR,
    output logic             C,
    output logic [CNT_W-1:0] car_cnt,
    output logic             served,
    output logic             wait_overflow
);

    localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2
    } state_t;

    state_t              state;
    logic                s1;
    logic                s2;
    logic                deb;
    logic                deb_prev;
    logic [DEB_W-1:0]    deb_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                arrival_c;
    logic                grant_c;

    assign arrival_c = deb & ~deb_prev;
    assign grant_c   = (state == REQ) && FG;

    // Two-flop synchroniser followed by a stability-count debouncer
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            deb      <= 1'b0;
            deb_prev <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            s1       <= loop_raw;
            s2       <= s1;
            deb_prev <= deb;
            if (s2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                deb     <= s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // Waiting-car counter; a grant clears it even if a car arrives on the same edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            car_cnt <= '0;
        end else if (grant_c) begin
            car_cnt <= '0;
        end else if (arrival_c && !FG && (car_cnt != '1)) begin
            car_cnt <= car_cnt + CNT_W'(1);
        end
    end

    // Request FSM with registered Moore outputs; wait_cnt holds the current REQ cycle number
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            C             <= 1'b0;
            served        <= 1'b0;
            wait_cnt      <= '0;
            wait_overflow <= 1'b0;
        end else begin
            served <= 1'b0;
            case (state)
                IDLE: begin
                    if (arrival_c && !FG) begin
                        state         <= REQ;
                        C             <= 1'b1;
                        wait_cnt      <= WAIT_W'(1);
                        wait_overflow <= (MAX_WAIT <= 1);
                    end
                end
                REQ: begin
                    if (FG) begin
                        state         <= SERVE;
                        C             <= 1'b0;
                        served        <= 1'b1;
                        wait_cnt      <= '0;
                        wait_overflow <= 1'b0;
                    end else begin
                        if (wait_cnt < WAIT_W'(MAX_WAIT)) begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                        wait_overflow <= (wait_cnt >= WAIT_W'(MAX_WAIT - 1));
                    end
                end
                SERVE: begin
                    if (!FG && FR) begin
                        if ((car_cnt != '0) || deb) begin
                            state         <= REQ;
                            C             <= 1'b1;
                            wait_cnt      <= WAIT_W'(1);
                            wait_overflow <= (MAX_WAIT <= 1);
                        end else begin
                            state <= IDLE;
                            C     <= 1'b0;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    C             <= 1'b0;
                    wait_cnt      <= '0;
                    wait_overflow <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/farm_car_detector.md
Name: farm_car_detector

Overview:
- Farm-road vehicle detector and request generator. Produces the car-request input C that the traffic light controller consumes.
- Closes the loop with the controller: takes the raw loop sensor, synchronises and debounces it, counts waiting cars, and holds C until the controller shows farm green.
- Sits between the road-side loop sensor pin and the controller's C input. Observes the controller's FG/FR light outputs.

Parameters:
- DEB_CYCLES, 4: consecutive stable cycles required on the synchronised sensor before the debounced level changes (min 1).
- CNT_W, 4: width of the waiting-car counter.
- MAX_WAIT, 48: cycles in REQ after which wait_overflow asserts.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- loop_raw  in  1  raw asynchronous loop sensor, 1 = vehicle over loop
- FG  in  1  farm-road green from the controller
- FR  in  1  farm-road red from the controller
- C  out  1  car request to the controller, registered
- car_cnt  out  CNT_W  cars waiting, not yet served
- served  out  1  one-cycle pulse when a pending request is granted
- wait_overflow  out  1  request pending for MAX_WAIT cycles or more

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; C, served, wait_overflow = 0; car_cnt = 0.
  - Synchroniser flops, debounced level, previous-level register, debounce counter and wait counter all cleared.
  - Reset mid-operation discards any pending request.
- Synchroniser: two flops on loop_raw (s1, s2).
- Debounce:
  - If s2 == deb, the counter clears.
  - Otherwise the counter increments. On the edge where the counter == DEB_CYCLES-1 and s2 still differs, deb <= s2 and the counter clears.
  - Pulses shorter than DEB_CYCLES cycles at s2 are ignored.
- Arrival event: deb=1 and deb_prev=0 (combinational, one cycle wide). deb_prev is deb delayed by one register.
- car_cnt:
  - Increments on an arrival when FG=0, saturating at 2^CNT_W-1.
  - Arrivals while FG=1 are not counted (the car passes on green).
  - Cleared on the edge that grants service (REQ with FG=1). Clear wins over a simultaneous arrival.
- FSM, Moore outputs, 3 states:
  - IDLE (C=0): arrival with FG=0 -> REQ. Otherwise stay.
  - REQ (C=1):
    - FG=1 -> SERVE, with served=1 for exactly the one cycle after the transition edge.
    - Otherwise stay; the wait counter increments, saturating.
  - SERVE (C=0): FR=1 and (car_cnt>0 or deb=1) -> REQ. FR=1 otherwise -> IDLE. Else stay.
- Latency: count the first edge that samples loop_raw=1 as edge 1.
  - deb rises at edge DEB_CYCLES+2.
  - C rises at edge DEB_CYCLES+3, i.e. edge 7 at the default.
- Wait counter:
  - Counts cycles spent in REQ.
  - wait_overflow is registered: 1 from the REQ cycle whose count reaches MAX_WAIT.
  - Counter and flag both clear on leaving REQ.
- Lights: FG and FR are used as levels only; no internal edge detection. FG=FR=1 is illegal input; FG has priority.

Test Plan:
- rst=0 for 3 cycles with loop_raw=1, then release -> all outputs 0 during reset; deb=1 at edge 6; C=1 from edge 7; car_cnt=1 (FR=1, FG=0).
- loop_raw=1 glitch for 3 cycles (DEB_CYCLES=4), FR=1 -> C stays 0, car_cnt stays 0.
- Three separate 10-cycle car pulses with FR=1 -> car_cnt=3, C=1. Then FG=1, FR=0 -> next edge: state SERVE, served=1 one cycle, car_cnt=0, C=0.
- Hold REQ with FG=0 for 60 cycles -> wait_overflow=1 from REQ cycle 48; 0 the cycle after FG=1 is taken.
- Car arrives while FG=1 and stays; then FR=1 -> car_cnt unchanged (0), SERVE->REQ, C=1 immediately after that edge.
- 17 arrivals (CNT_W=4) -> car_cnt saturates at 15. Then rst=0 while in REQ -> state IDLE, C=0, car_cnt=0.
